// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with one word per line.
// COMPARE spends one cycle on the registered tag lookup and one cycle acting on it.
module cache_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] COMPARE   = 2'd1;
  localparam logic [1:0] WRITEBACK = 2'd2;
  localparam logic [1:0] ALLOCATE  = 2'd3;

  logic [1:0]        state;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              cmp_p1;
  logic              hit_p1;
  logic              victim_dirty_p1;
  logic              first;
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               accept;
  logic               act;
  logic               mem_done;

  assign idx      = req_addr[INDEX_W-1:0];
  assign req_tag  = req_addr[ADDR_W-1:INDEX_W];
  assign accept   = (state == IDLE) && cpu_req && !cpu_ready;
  assign act      = (state == COMPARE) && cmp_p1;
  // An ack only counts while a transaction is actually outstanding.
  assign mem_done = mem_req && mem_ack;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      cmp_p1     <= 1'b0;
      first      <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= COMPARE;
            cmp_p1 <= 1'b0;
            first  <= 1'b1;
          end
        end
        COMPARE: begin
          if (!cmp_p1) begin
            cmp_p1 <= 1'b1;
          end else begin
            cmp_p1 <= 1'b0;
            first  <= 1'b0;
            if (hit_p1) begin
              cpu_ready <= 1'b1;
              state     <= IDLE;
              if (req_we) dirty[idx] <= 1'b1;
              else        cpu_rdata  <= data_mem[idx];
              if (first) hit_count <= sat_inc(hit_count);
            end else begin
              if (first) miss_count <= sat_inc(miss_count);
              if (victim_dirty_p1) begin
                state     <= WRITEBACK;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {tag_mem[idx], idx};
                mem_wdata <= data_mem[idx];
              end else begin
                state <= ALLOCATE;
              end
            end
          end
        end
        WRITEBACK: begin
          if (mem_done) begin
            dirty[idx] <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            state      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          // The first ALLOCATE cycle always leaves mem_req low, separating it from a writeback.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= req_addr;
          end else if (mem_ack) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            mem_req    <= 1'b0;
            state      <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_we    <= cpu_we;
      req_addr  <= cpu_addr;
      req_wdata <= cpu_wdata;
    end
    // p0 -> p1: registered tag lookup, consumed on the acting COMPARE cycle
    if ((state == COMPARE) && !cmp_p1) begin
      hit_p1          <= valid[idx] && (tag_mem[idx] == req_tag);
      victim_dirty_p1 <= valid[idx] && dirty[idx];
    end
    if (rst_n) begin
      if (act && hit_p1 && req_we) begin
        data_mem[idx] <= req_wdata;
      end
      if ((state == ALLOCATE) && mem_done) begin
        data_mem[idx] <= mem_rdata;
        tag_mem[idx]  <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: the driver queues expected CPU and memory
// transactions, and a negedge monitor pops and compares them as they appear.
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  cache_ctrl #(.ADDR_W(16), .DATA_W(32), .INDEX_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct packed { logic is_read; logic [31:0] rdata; } cpu_exp_t;
  typedef struct packed { logic we; logic [15:0] addr; logic [31:0] data; } mem_exp_t;
  cpu_exp_t exp_cpu[$];
  mem_exp_t exp_mem[$];
  int total = 0;
  int bad   = 0;

  // Memory model: fixed contents except the most recent writeback.
  logic        zero_wait = 1'b0;
  logic        ack_en    = 1'b1;
  logic        ack_reg   = 1'b0;
  int          lat_cnt   = 0;
  int          mem_lat   = 3;
  logic        wb_valid  = 1'b0;
  logic [15:0] wb_addr   = '0;
  logic [31:0] wb_data   = '0;

  function automatic logic [31:0] base_val(input logic [15:0] a);
    case (a)
      16'h0010: return 32'hDEADBEEF;
      16'h0020: return 32'hCAFEF00D;
      default:  return {16'hA5A5, a};
    endcase
  endfunction

  assign mem_ack   = zero_wait ? mem_req : ack_reg;
  assign mem_rdata = (wb_valid && (wb_addr == mem_addr)) ? wb_data : base_val(mem_addr);

  always @(posedge clk) begin
    ack_reg <= 1'b0;
    if (mem_req && mem_ack && mem_we) begin
      wb_valid <= 1'b1;
      wb_addr  <= mem_addr;
      wb_data  <= mem_wdata;
    end
    if (!zero_wait && ack_en && mem_req && !ack_reg) begin
      if (lat_cnt == mem_lat - 1) begin
        ack_reg <= 1'b1;
        lat_cnt <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  logic prev_ready = 1'b0;
  logic prev_done  = 1'b0;

  always @(negedge clk) begin
    cpu_exp_t ce;
    mem_exp_t me;
    if (rst_n) begin
      if (cpu_ready) begin
        total++;
        if (exp_cpu.size() == 0) begin
          bad++;
          $display("FAIL cpu_resp: unexpected cpu_ready rdata=%h", cpu_rdata);
        end else begin
          ce = exp_cpu.pop_front();
          if (prev_ready || (ce.is_read && (cpu_rdata !== ce.rdata))) begin
            bad++;
            $display("FAIL cpu_resp: rdata=%h prev_ready=%0b, want rdata=%h prev_ready=0",
                     cpu_rdata, prev_ready, ce.rdata);
          end
        end
      end
      if (mem_req && mem_ack) begin
        total++;
        if (exp_mem.size() == 0) begin
          bad++;
          $display("FAIL mem_txn: unexpected we=%0b addr=%h", mem_we, mem_addr);
        end else begin
          me = exp_mem.pop_front();
          if ((mem_we !== me.we) || (mem_addr !== me.addr) || (me.we && (mem_wdata !== me.data))) begin
            bad++;
            $display("FAIL mem_txn: we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, me.we, me.addr, me.data);
          end
        end
      end
      if (prev_done) begin
        total++;
        if (mem_req !== 1'b0) begin
          bad++;
          $display("FAIL mem_gap: mem_req=%b after ack, want 0", mem_req);
        end
      end
    end
    prev_ready <= cpu_ready;
    prev_done  <= mem_req && mem_ack;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_mem(input logic we, input logic [15:0] addr, input logic [31:0] data);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.data = data;
    exp_mem.push_back(m);
  endtask

  task automatic access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input bit is_hit);
    cpu_exp_t e;
    int n;
    e.is_read = !we;
    e.rdata   = exp_rd;
    exp_cpu.push_back(e);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    n = 0;
    while (!cpu_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) begin
      total++;
      bad++;
      $display("FAIL access_timeout: addr=%h no cpu_ready after %0d cycles", addr, n);
    end else if (is_hit) begin
      chk("hit_latency", n, 2);
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    rst_n = 1'b1;

    // Cold read miss with a 3-cycle memory.
    push_mem(1'b0, 16'h0010, 32'h0);
    access(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("miss1_miss_count", {16'd0, miss_count}, 32'd1);
    chk("miss1_hit_count", {16'd0, hit_count}, 32'd0);

    access(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b1);
    chk("hit1_hit_count", {16'd0, hit_count}, 32'd1);

    // Write hit makes the line dirty; a conflicting read evicts it.
    access(1'b1, 16'h0010, 32'h12345678, 32'h0, 1'b1);
    chk("whit_hit_count", {16'd0, hit_count}, 32'd2);
    push_mem(1'b1, 16'h0010, 32'h12345678);
    push_mem(1'b0, 16'h0020, 32'h0);
    access(1'b0, 16'h0020, 32'h0, 32'hCAFEF00D, 1'b0);
    chk("evict_miss_count", {16'd0, miss_count}, 32'd2);
    chk("evict_hit_count", {16'd0, hit_count}, 32'd2);

    // Zero-wait memory.
    zero_wait = 1'b1;
    push_mem(1'b0, 16'h0005, 32'h0);
    access(1'b0, 16'h0005, 32'h0, 32'hA5A50005, 1'b0);
    chk("zw_miss_count", {16'd0, miss_count}, 32'd3);
    zero_wait = 1'b0;

    // Reset while ALLOCATE waits for a withheld ack.
    ack_en = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = '0;
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_mem_req_seen", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_hit_count", {16'd0, hit_count}, 32'd0);
    chk("abort_miss_count", {16'd0, miss_count}, 32'd0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    push_mem(1'b0, 16'h0010, 32'h0);
    access(1'b0, 16'h0010, 32'h0, 32'h12345678, 1'b0);
    chk("post_rst_miss_count", {16'd0, miss_count}, 32'd1);
    chk("post_rst_hit_count", {16'd0, hit_count}, 32'd0);

    // Saturation: preload the hit counter one below the ceiling.
    @(negedge clk);
    force dut.hit_count = 16'hFFFE;
    @(negedge clk);
    release dut.hit_count;
    access(1'b0, 16'h0010, 32'h0, 32'h12345678, 1'b1);
    chk("sat_hit_count_1", {16'd0, hit_count}, 32'h0000FFFF);
    access(1'b0, 16'h0010, 32'h0, 32'h12345678, 1'b1);
    chk("sat_hit_count_2", {16'd0, hit_count}, 32'h0000FFFF);
    chk("sat_miss_count", {16'd0, miss_count}, 32'd1);

    repeat (2) @(negedge clk);
    chk("cpu_queue_left", exp_cpu.size(), 32'd0);
    chk("mem_queue_left", exp_mem.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
